// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, instruction size, IF/ID payload.
package fetch_ctrl_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
    } ifid_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Program counter register with word incrementer; redirect load wins over advance.
module pc_reg
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic            adv_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_c
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Carry out of bit 31 is dropped, so the PC wraps modulo 2^32.
    assign pc_plus4_c = pc_q + XLEN'(INST_BYTES);
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = align_pc(load_pc_i);
        end else if (adv_i) begin
            pc_d = pc_plus4_c;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, IF/ID register, boot/run/halt FSM, fetch counter.
// Define FETCH_BOUND_EN to halt fetch at the end of the instruction ROM.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 64
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  rom_a,
    input  logic [XLEN-1:0]  rom_inst,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_pc4,
    output logic [XLEN-1:0]  id_inst,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

`ifdef FETCH_BOUND_EN
    localparam logic [XLEN-1:0] ROM_BYTES = XLEN'(ROM_WORDS * INST_BYTES);
    localparam logic [XLEN-1:0] LAST_PC   = XLEN'(ROM_WORDS * INST_BYTES - INST_BYTES);
`endif

    fetch_state_e     state_q, state_d;
    ifid_t            ifid_q, ifid_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pc_load, pc_adv;
    logic [XLEN-1:0]  pc, pc_plus4;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .clrn       (clrn),
        .load_i     (pc_load),
        .load_pc_i  (redirect_pc),
        .adv_i      (pc_adv),
        .pc_o       (pc),
        .pc_plus4_c (pc_plus4)
    );

    assign rom_a = align_pc(pc);

    // Redirect overrides everything, including stall and HALT.
    always_comb begin
        state_d = state_q;
        ifid_d  = ifid_q;
        valid_d = valid_q;
        pc_load = 1'b0;
        pc_adv  = 1'b0;
        if (redirect) begin
            pc_load     = 1'b1;
            valid_d     = 1'b0;
            ifid_d.inst = '0;
            state_d     = RUN;
`ifdef FETCH_BOUND_EN
            if (align_pc(redirect_pc) >= ROM_BYTES) begin
                state_d = HALT;
            end
`endif
        end else begin
            case (state_q)
                BOOT: begin
                    valid_d = 1'b0;
                    state_d = RUN;
                end
                RUN: begin
                    if (!stall) begin
                        valid_d     = 1'b1;
                        ifid_d.pc   = pc;
                        ifid_d.pc4  = pc_plus4;
                        ifid_d.inst = rom_inst;
                        pc_adv      = 1'b1;
`ifdef FETCH_BOUND_EN
                        if (pc == LAST_PC) begin
                            state_d = HALT;
                        end
`endif
                    end
                end
                HALT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pc_adv && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= BOOT;
            ifid_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign id_valid    = valid_q;
    assign id_pc       = ifid_q.pc;
    assign id_pc4      = ifid_q.pc4;
    assign id_inst     = ifid_q.inst;
    assign fetch_count = cnt_q;

`ifdef FETCH_BOUND_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, giving the PC loaded on reset.
REQ-002 SHALL have parameter ROM_WORDS, default 64, giving the instruction ROM depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  as the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clrn  input  1  as the asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  as the hazard-unit hold request for the PC and IF/ID register.
REQ-006 SHALL have port redirect  input  1  as the taken-branch/jump indication from ID.
REQ-007 SHALL have port redirect_pc  input  32  as the target byte address for a redirect.
REQ-008 SHALL have port rom_a  output  32  as the byte address driven to the instruction ROM.
REQ-009 SHALL have port rom_inst  input  32  as the combinational ROM read data for rom_a.
REQ-010 SHALL have port id_valid  output  1  as the flag marking that the IF/ID register holds a real instruction.
REQ-011 SHALL have ports id_pc, id_pc4 and id_inst, each output 32, as the IF/ID register: fetch PC, PC+4 and instruction word.
REQ-012 SHALL have port halted  output  1  as the flag marking that fetch is stopped at the ROM bound.
REQ-013 SHALL have port fetch_count  output  16  as the number of instructions delivered to ID.

Function
REQ-014 SHALL drive rom_a combinationally from the PC register, with bits [1:0] forced to 00.
REQ-015 SHALL implement the FSM states BOOT, RUN and HALT; BOOT SHALL go to RUN unconditionally after one cycle, producing one bubble with id_valid=0.
REQ-016 SHALL, in RUN with stall=0 and redirect=0, on each edge latch id_inst<=rom_inst, id_pc<=pc, id_pc4<=pc+4 and id_valid<=1, then advance pc<=pc+4, giving one instruction per cycle and single-cycle fetch latency.
REQ-017 SHALL, in RUN with stall=1 and redirect=0, hold pc and all id_* outputs unchanged.
REQ-018 SHALL, on redirect=1 in any state, load pc<=redirect_pc with bits [1:0] cleared, and set id_valid<=0 and id_inst<=0 to flush.
REQ-019 SHALL give redirect priority over stall when both are asserted in the same cycle.
REQ-020 SHALL compute PC arithmetic modulo 2^32, with carry discarded.
REQ-021 SHALL increment fetch_count on each cycle in which id_valid is written to 1, saturating at 16'hFFFF.
REQ-022 SHALL, in HALT, hold pc, keep id_valid=0 and assert halted=1; only a redirect leaves HALT.

Reset
REQ-023 SHALL, while clrn=0 and independent of clk, force pc=RESET_PC, state=BOOT, id_valid=0, id_pc=0, id_pc4=0, id_inst=0, halted=0 and fetch_count=0.
REQ-024 SHALL treat reset asserted mid-stall or mid-redirect the same as any other reset, with no pending redirect retained.

Configuration
REQ-025 SHALL, when FETCH_BOUND_EN is defined, enter HALT on the edge that delivers the instruction at byte address ROM_WORDS*4-4, and SHALL enter HALT directly when a redirect target is >= ROM_WORDS*4.
REQ-026 SHALL, when FETCH_BOUND_EN is defined, make a redirect from HALT to an in-range target return to RUN, with the first valid instruction one cycle later.
REQ-027 SHALL, when FETCH_BOUND_EN is undefined, never enter HALT, let pc increment freely so that ROM indexing wraps, and tie halted to 0.

Structure
REQ-028 SHALL place the FSM state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2) and the constant INST_BYTES=4 in the shared CPU package/define file.
REQ-029 SHALL place the PC register and incrementer in sub-module pc_reg; the IF/ID register, FSM and counter remain in fetch_ctrl.

Verification
REQ-030 SHALL cover reset release with the ROM holding 0x00100443 and 0x00201025 -> cycle 1 id_valid=0 (BOOT); cycle 2 id_inst=0x00100443, id_pc=0; cycle 3 id_inst=0x00201025, id_pc=4, id_pc4=8.
REQ-031 SHALL cover stall held for 3 cycles at pc=0x08 -> id_* frozen, rom_a=0x08 throughout, fetch_count unchanged; next edge id_pc=0x08.
REQ-032 SHALL cover redirect=1 together with stall=1, redirect_pc=0x13 -> pc=0x10, id_valid=0 next cycle, id_pc=0x10 the cycle after.
REQ-033 SHALL cover, with FETCH_BOUND_EN defined and ROM_WORDS=64, sequential run to 0xFC -> halted=1 after 0xFC is delivered, rom_a held at 0x100; then redirect_pc=0x00 -> RUN, id_pc=0 one cycle later.
REQ-034 SHALL cover, with FETCH_BOUND_EN undefined, run past 0xFC -> rom_a=0x100, which the ROM sees as index 0, halted=0.
REQ-035 SHALL cover asserting clrn=0 asynchronously mid-cycle with fetch_count=0x0005 -> all outputs reset immediately, fetch_count=0, without waiting for clk.
